rng_stream_ctrl: RTL



---
 rtl/rng_pkg.sv | 28 ++
 rtl/rng_sync_fifo.sv | 61 ++++++
 rtl/rng_stream_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG streaming controller.
// Optional build macro: RNG_VON_NEUMANN_EN (Von Neumann debiasing of accepted bits).
package rng_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } rng_state_t;

    typedef struct packed {
        logic              tlast;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

    // A nonzero byte request shorter than one word still produces a single word.
    function automatic logic [29:0] send_words_of(input logic [31:0] bytes);
        if ((bytes[31:2] == 30'd0) && (bytes != 32'd0)) begin
            return 30'd1;
        end
        return bytes[31:2];
    endfunction

endpackage

// File: rtl/rng_sync_fifo.sv
// First-word-fall-through word FIFO carrying {tlast, data} entries.
// A write while full is accepted only when a read frees a slot in the same cycle.
module rng_sync_fifo
    import rng_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  fifo_entry_t wr_data,
    input  logic        rd_en,
    output fifo_entry_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    fifo_entry_t    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_rd;
    logic           do_wr;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because empty gates the output.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + (AW+1)'(1);
            end else if (!do_wr && do_rd) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rng_stream_ctrl.sv
// Packs decimated raw TRNG bits into 32-bit words and streams them over AXI4-Stream.
// Optional build macro: RNG_VON_NEUMANN_EN pairs accepted bits (01->0, 10->1, 00/11 dropped).
module rng_stream_ctrl
    import rng_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DEC_W      = 16
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic        RNG_GO,
    input  logic        RNG_STOP,
    input  logic [31:0] RNG_SEND_BYTES,
    input  logic [31:0] RNG_DMA_BYTES,
    input  logic [31:0] RNG_PARAMETER,
    output logic        RNG_RUN,
    output logic        RNG_OVER,
    output logic [31:0] RNG_SENT_BYTES,
    output logic [31:0] RNG_STATS,
    input  logic        RAW_BIT,
    input  logic        RAW_VALID,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic        M_AXIS_TLAST
);

    rng_state_t        state;
    logic [29:0]       send_words;
    logic [29:0]       dma_words;
    logic [29:0]       word_cnt;
    logic [29:0]       pkt_cnt;
    logic [DEC_W-1:0]  dec_n;
    logic [DEC_W-1:0]  dec_cnt;
    logic [WORD_W-1:0] shifter;
    logic [WORD_W-1:0] word_data;
    logic [4:0]        bit_cnt;
    logic              word_ready;

    logic              dec_hit;
    logic              is_final;
    logic              tag;
    logic              completing;
    logic              sample_en;
    logic              accept;
    logic              pack_valid;
    logic              pack_bit;
    logic              pop;
    logic              push_room;
    logic              run_push;
    logic              flush_push;
    logic              fifo_wr;
    logic              fifo_full;
    logic              fifo_empty;
    fifo_entry_t       fifo_din;
    fifo_entry_t       fifo_dout;
    logic              unused_inputs;

    assign unused_inputs = ^{RNG_DMA_BYTES[1:0], RNG_PARAMETER};
    assign M_AXIS_TVALID = !fifo_empty;
    assign M_AXIS_TDATA  = fifo_dout.data;
    assign M_AXIS_TLAST  = fifo_dout.tlast;
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;

`ifdef RNG_VON_NEUMANN_EN
    logic vn_have;
    logic vn_first;

    // Holds the first half of a Von Neumann pair; dropped on GO and on STOP.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            vn_have  <= 1'b0;
            vn_first <= 1'b0;
        end else if ((state == IDLE) && RNG_GO) begin
            vn_have  <= 1'b0;
            vn_first <= 1'b0;
        end else if ((state == RUN) && RNG_STOP) begin
            vn_have  <= 1'b0;
        end else if (accept) begin
            vn_have <= !vn_have;
            if (!vn_have) begin
                vn_first <= RAW_BIT;
            end
        end
    end
`endif

    // Sampling qualifiers, packet tagging and FIFO write selection.
    always_comb begin
        dec_hit    = (dec_cnt == dec_n - DEC_W'(1));
        is_final   = (send_words != 30'd0) && (word_cnt + 30'd1 == send_words);
        tag        = ((dma_words != 30'd0) && (pkt_cnt + 30'd1 == dma_words)) || is_final;
        completing = (state == RUN) && word_ready && is_final;
        sample_en  = (state == RUN) && !RNG_STOP && !completing;
        accept     = sample_en && RAW_VALID && dec_hit;
`ifdef RNG_VON_NEUMANN_EN
        pack_valid = accept && vn_have && (vn_first != RAW_BIT);
        pack_bit   = vn_first;
`else
        pack_valid = accept;
        pack_bit   = RAW_BIT;
`endif
        run_push   = (state == RUN) && word_ready;
        push_room  = !fifo_full || pop;
        flush_push = (state == FLUSH) && (pkt_cnt != 30'd0) && !fifo_full;
        fifo_wr    = (run_push && push_room) || flush_push;
        fifo_din.tlast = flush_push ? 1'b1 : tag;
        fifo_din.data  = flush_push ? '0 : word_data;
    end

    // Controller FSM with run configuration, packing datapath and status registers.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state          <= IDLE;
            RNG_RUN        <= 1'b0;
            RNG_OVER       <= 1'b0;
            RNG_SENT_BYTES <= '0;
            RNG_STATS      <= '0;
            send_words     <= '0;
            dma_words      <= '0;
            word_cnt       <= '0;
            pkt_cnt        <= '0;
            dec_n          <= DEC_W'(1);
            dec_cnt        <= '0;
            shifter        <= '0;
            word_data      <= '0;
            bit_cnt        <= '0;
            word_ready     <= 1'b0;
        end else begin
            if (pop) begin
                RNG_SENT_BYTES <= RNG_SENT_BYTES + 32'(BYTES_PER_WORD);
            end
            case (state)
                IDLE: begin
                    if (RNG_GO) begin
                        state          <= RUN;
                        RNG_RUN        <= 1'b1;
                        send_words     <= send_words_of(RNG_SEND_BYTES);
                        dma_words      <= RNG_DMA_BYTES[31:2];
                        dec_n          <= (RNG_PARAMETER[DEC_W-1:0] == '0) ? DEC_W'(1)
                                                                          : RNG_PARAMETER[DEC_W-1:0];
                        RNG_SENT_BYTES <= '0;
                        RNG_STATS      <= '0;
                        RNG_OVER       <= 1'b0;
                        shifter        <= '0;
                        bit_cnt        <= '0;
                        dec_cnt        <= '0;
                        word_cnt       <= '0;
                        pkt_cnt        <= '0;
                        word_ready     <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample_en && RAW_VALID) begin
                        dec_cnt <= dec_hit ? '0 : dec_cnt + DEC_W'(1);
                    end
                    if (pack_valid) begin
                        shifter <= {pack_bit, shifter[WORD_W-1:1]};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) begin
                            word_data <= {pack_bit, shifter[WORD_W-1:1]};
                        end
                        if (pack_bit && (RNG_STATS != 32'hFFFF_FFFF)) begin
                            RNG_STATS <= RNG_STATS + 32'd1;
                        end
                    end
                    word_ready <= pack_valid && (bit_cnt == 5'd31);
                    if (run_push) begin
                        word_cnt <= word_cnt + 30'd1;
                        pkt_cnt  <= tag ? 30'd0 : pkt_cnt + 30'd1;
                        if (!push_room) begin
                            RNG_OVER <= 1'b1;
                        end
                    end
                    if (completing) begin
                        state <= DRAIN;
                    end else if (RNG_STOP) begin
                        state   <= FLUSH;
                        shifter <= '0;
                        bit_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (pkt_cnt == 30'd0) begin
                        state <= DRAIN;
                    end else if (!fifo_full) begin
                        pkt_cnt <= 30'd0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state   <= IDLE;
                        RNG_RUN <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    RNG_RUN <= 1'b0;
                end
            endcase
        end
    end

    rng_sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (AXIS_ACLK),
        .rst_n   (AXIS_ARESETN),
        .wr_en   (fifo_wr),
        .wr_data (fifo_din),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
